// File: rtl/hilo_muldiv_sequencer_if.sv
// HI/LO unit bus: instruction decode and operands in, HI/LO state and status out.
interface hilo_muldiv_sequencer_if #(
    parameter int unsigned WIDTH = 32
);
    logic [2:0]       hilo_type;
    logic [1:0]       md_sel;
    logic [WIDTH-1:0] rs_data;
    logic [WIDTH-1:0] rt_data;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] hilo_rdata;
    logic             stall;
    logic             busy;
    logic             div_zero;

    // Core side: issues HI/LO instructions and supplies register operands.
    modport master (
        output hilo_type, md_sel, rs_data, rt_data,
        input  hi, lo, hilo_rdata, stall, busy, div_zero
    );

    // Unit side.
    modport slave (
        input  hilo_type, md_sel, rs_data, rt_data,
        output hi, lo, hilo_rdata, stall, busy, div_zero
    );
endinterface

// File: rtl/hilo_muldiv_sequencer.sv
// Iterative mult/multu/div/divu sequencer owning the HI/LO register pair.
// Operands are converted to magnitudes at start, iterated for WIDTH cycles,
// then sign-corrected in a single FIX cycle before HI/LO are written.
module hilo_muldiv_sequencer #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 5
) (
    input logic                    clk,
    input logic                    reset,
    hilo_muldiv_sequencer_if.slave bus
);

    localparam logic [2:0] HtStart = 3'b111;
    localparam logic [2:0] HtMthi  = 3'b101;
    localparam logic [2:0] HtMtlo  = 3'b011;
    localparam logic [2:0] HtMfhi  = 3'b100;
    localparam logic [2:0] HtMflo  = 3'b010;
    localparam logic [2:0] HtNone  = 3'b000;

    localparam logic [CNT_W-1:0] LastCnt = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    // acc: upper product half / partial remainder.
    // acc_lo: multiplier shifting out / dividend shifting out, quotient shifting in.
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
    logic [WIDTH-1:0] op_a_q, op_a_d;
    logic [WIDTH-1:0] op_b_q, op_b_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             is_div_q, is_div_d;
    logic             neg_a_q, neg_a_d;
    logic             neg_res_q, neg_res_d;
    logic             div_zero_q, div_zero_d;

    // Start-time operand conditioning.
    logic             in_signed;
    logic             rs_neg;
    logic             rt_neg;
    logic [WIDTH-1:0] rs_abs;
    logic [WIDTH-1:0] rt_abs;

    assign in_signed = ~bus.md_sel[0];
    assign rs_neg    = in_signed & bus.rs_data[WIDTH-1];
    assign rt_neg    = in_signed & bus.rt_data[WIDTH-1];
    assign rs_abs    = rs_neg ? (~bus.rs_data + 1'b1) : bus.rs_data;
    assign rt_abs    = rt_neg ? (~bus.rt_data + 1'b1) : bus.rt_data;

    // Iteration datapath.
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;

    assign mul_sum   = {1'b0, acc_q} + (acc_lo_q[0] ? {1'b0, op_a_q} : {(WIDTH+1){1'b0}});
    assign div_shift = {acc_q, acc_lo_q[WIDTH-1]};
    // Bit WIDTH set means the trial subtraction borrowed: restore.
    assign div_diff  = div_shift - {1'b0, op_b_q};
    assign prod      = {acc_q, acc_lo_q};
    assign prod_fix  = neg_res_q ? (~prod + 1'b1) : prod;

    // State and datapath registers; synchronous active-low reset aborts any sequence.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            acc_q      <= '0;
            acc_lo_q   <= '0;
            op_a_q     <= '0;
            op_b_q     <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            is_div_q   <= 1'b0;
            neg_a_q    <= 1'b0;
            neg_res_q  <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            acc_lo_q   <= acc_lo_d;
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            is_div_q   <= is_div_d;
            neg_a_q    <= neg_a_d;
            neg_res_q  <= neg_res_d;
            div_zero_q <= div_zero_d;
        end
    end

    // Next-state: instruction decode in IDLE, one iteration per CALC cycle, sign fix in FIX.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        acc_lo_d   = acc_lo_q;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        is_div_d   = is_div_q;
        neg_a_d    = neg_a_q;
        neg_res_d  = neg_res_q;
        div_zero_d = 1'b0;

        case (state_q)
            StIdle: begin
                case (bus.hilo_type)
                    HtStart: begin
                        is_div_d  = bus.md_sel[1];
                        neg_a_d   = rs_neg;
                        neg_res_d = rs_neg ^ rt_neg;
                        op_a_d    = rs_abs;
                        op_b_d    = rt_abs;
                        acc_d     = '0;
                        acc_lo_d  = bus.md_sel[1] ? rs_abs : rt_abs;
                        cnt_d     = '0;
                        state_d   = StCalc;
                    end
                    HtMthi:  hi_d = bus.rs_data;
                    HtMtlo:  lo_d = bus.rs_data;
                    default: ;
                endcase
            end
            StCalc: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (is_div_q) begin
                    if (!div_diff[WIDTH]) begin
                        acc_d    = div_diff[WIDTH-1:0];
                        acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_d    = div_shift[WIDTH-1:0];
                        acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    acc_d    = mul_sum[WIDTH:1];
                    acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
                end
                if (cnt_q == LastCnt) begin
                    state_d = StFix;
                end
            end
            StFix: begin
                if (!is_div_q) begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end else if (op_b_q == '0) begin
                    // Divide by zero: all-ones quotient, original dividend as remainder.
                    lo_d       = '1;
                    hi_d       = neg_a_q ? (~op_a_q + 1'b1) : op_a_q;
                    div_zero_d = 1'b1;
                end else begin
                    lo_d = neg_res_q ? (~acc_lo_q + 1'b1) : acc_lo_q;
                    hi_d = neg_a_q ? (~acc_q + 1'b1) : acc_q;
                end
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Read mux for mfhi/mflo; everything else reads as zero.
    always_comb begin
        bus.hilo_rdata = '0;
        case (bus.hilo_type)
            HtMfhi:  bus.hilo_rdata = hi_q;
            HtMflo:  bus.hilo_rdata = lo_q;
            default: bus.hilo_rdata = '0;
        endcase
    end

    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;
    assign bus.busy     = (state_q != StIdle);
    assign bus.stall    = (state_q != StIdle) && (bus.hilo_type != HtNone);
    assign bus.div_zero = div_zero_q;

endmodule

// File: tb/tb_hilo_muldiv_sequencer.sv
// Scoreboarded bench for the HI/LO mul/div sequencer.
module tb_hilo_muldiv_sequencer;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    hilo_muldiv_sequencer_if #(.WIDTH(32)) bus ();

    hilo_muldiv_sequencer #(.WIDTH(32), .CNT_W(5)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference arithmetic for one mult/div operation.
    function automatic exp_t model(input logic [1:0] sel, input logic [31:0] a,
                                   input logic [31:0] b);
        exp_t               e;
        logic [63:0]        p;
        logic signed [31:0] sa;
        logic signed [31:0] sbv;
        e.dz = 1'b0;
        sa   = a;
        sbv  = b;
        if (!sel[1]) begin
            if (sel[0]) p = {32'b0, a} * {32'b0, b};
            else        p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
            e.hi = p[63:32];
            e.lo = p[31:0];
        end else if (b == 32'h0) begin
            e.lo = 32'hFFFFFFFF;
            e.hi = a;
            e.dz = 1'b1;
        end else if (sel[0]) begin
            e.lo = a / b;
            e.hi = a % b;
        end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
            e.lo = 32'h80000000;
            e.hi = 32'h0;
        end else begin
            e.lo = sa / sbv;
            e.hi = sa % sbv;
        end
        return e;
    endfunction

    task automatic idle_cycle(input logic [2:0] t, input logic [31:0] rs);
        @(negedge clk);
        bus.hilo_type = t;
        bus.md_sel    = 2'b00;
        bus.rs_data   = rs;
        bus.rt_data   = 32'h0;
        #1;
    endtask

    task automatic issue_start(input logic [1:0] sel, input logic [31:0] a,
                               input logic [31:0] b, input bit push);
        @(negedge clk);
        bus.hilo_type = 3'b111;
        bus.md_sel    = sel;
        bus.rs_data   = a;
        bus.rt_data   = b;
        if (push) sb.push_back(model(sel, a, b));
        #1;
    endtask

    // Holds an instruction until busy drops; returns on the first idle cycle (T+34).
    task automatic wait_idle(input logic [2:0] hold, input logic [1:0] hsel,
                             input logic [31:0] hrs, input logic [31:0] hrt,
                             input bit scramble,
                             output int nbusy, output int nstall, output int ndz);
        nbusy  = 0;
        nstall = 0;
        ndz    = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            bus.hilo_type = hold;
            bus.md_sel    = hsel;
            bus.rs_data   = scramble ? $urandom : hrs;
            bus.rt_data   = scramble ? $urandom : hrt;
            #1;
            if (!bus.busy) break;
            nbusy++;
            if (bus.stall) nstall++;
            if (bus.div_zero) ndz++;
        end
    endtask

    task automatic test_reset();
        reset         = 1'b0;
        bus.hilo_type = 3'b000;
        bus.md_sel    = 2'b00;
        bus.rs_data   = 32'h0;
        bus.rt_data   = 32'h0;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (bus.hi !== 32'h0) begin failures++; $display("FAIL reset_hi: got %h expected 0", bus.hi); end
        checks++; if (bus.lo !== 32'h0) begin failures++; $display("FAIL reset_lo: got %h expected 0", bus.lo); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        checks++; if (bus.stall !== 1'b0) begin failures++; $display("FAIL reset_stall: got %b expected 0", bus.stall); end
        checks++; if (bus.div_zero !== 1'b0) begin failures++; $display("FAIL reset_dz: got %b expected 0", bus.div_zero); end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic run_table(input string tag, input logic [1:0] sel[8],
                             input logic [31:0] as[8], input logic [31:0] bs[8]);
        int nb, ns, nd;
        exp_t e;
        for (int i = 0; i < 8; i++) begin
            issue_start(sel[i], as[i], bs[i], 1'b1);
            wait_idle(3'b000, 2'b00, 32'h0, 32'h0, 1'b1, nb, ns, nd);
            e = sb.pop_front();
            checks++; if (nb != 33) begin failures++; $display("FAIL %s_busy[%0d]: got %0d cycles expected 33", tag, i, nb); end
            checks++; if (ns != 0) begin failures++; $display("FAIL %s_nostall[%0d]: got %0d expected 0", tag, i, ns); end
            checks++; if (bus.hi !== e.hi) begin failures++; $display("FAIL %s_hi[%0d]: got %h expected %h", tag, i, bus.hi, e.hi); end
            checks++; if (bus.lo !== e.lo) begin failures++; $display("FAIL %s_lo[%0d]: got %h expected %h", tag, i, bus.lo, e.lo); end
            checks++; if (bus.div_zero !== e.dz) begin failures++; $display("FAIL %s_dz[%0d]: got %b expected %b", tag, i, bus.div_zero, e.dz); end
        end
    endtask

    task automatic test_mult();
        logic [1:0]  sel[8] = '{2'b00, 2'b01, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 2'b01};
        logic [31:0] as[8]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h12345678, 32'h80000000,
                                32'hFFFFFFFF, 32'h0, $urandom, $urandom};
        logic [31:0] bs[8]  = '{32'h00000002, 32'h00000002, 32'h9ABCDEF0, 32'h80000000,
                                32'hFFFFFFFF, 32'h1234, $urandom, $urandom};
        run_table("mult", sel, as, bs);
        // Unsigned reference vector, known constant.
        issue_start(2'b01, 32'hFFFFFFFF, 32'h00000002, 1'b0);
        begin
            int nb, ns, nd;
            wait_idle(3'b000, 2'b00, 32'h0, 32'h0, 1'b1, nb, ns, nd);
        end
        checks++; if (bus.hi !== 32'h00000001) begin failures++; $display("FAIL multu_const_hi: got %h expected 00000001", bus.hi); end
        checks++; if (bus.lo !== 32'hFFFFFFFE) begin failures++; $display("FAIL multu_const_lo: got %h expected fffffffe", bus.lo); end
    endtask

    task automatic test_div();
        logic [1:0]  sel[8] = '{2'b10, 2'b10, 2'b11, 2'b10, 2'b10, 2'b11, 2'b10, 2'b11};
        logic [31:0] as[8]  = '{32'hFFFFFFF9, 32'h80000000, 32'h00000100, 32'h00000007,
                                32'h80000000, 32'hFFFFFFFF, $urandom, $urandom};
        logic [31:0] bs[8]  = '{32'h00000002, 32'hFFFFFFFF, 32'h00000007, 32'hFFFFFFFE,
                                32'h00000003, 32'h00000010, $urandom | 32'h1, $urandom | 32'h1};
        run_table("div", sel, as, bs);
    endtask

    task automatic test_div_zero();
        logic [1:0]  sel[2] = '{2'b11, 2'b10};
        logic [31:0] as[2]  = '{32'h12345678, 32'hFFFFFFF0};
        int nb, ns, nd;
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            issue_start(sel[i], as[i], 32'h0, 1'b1);
            wait_idle(3'b000, 2'b00, 32'h0, 32'h0, 1'b1, nb, ns, nd);
            e = sb.pop_front();
            checks++; if (nb != 33) begin failures++; $display("FAIL dz_busy[%0d]: got %0d expected 33", i, nb); end
            checks++; if (nd != 0) begin failures++; $display("FAIL dz_early[%0d]: got %0d pulses expected 0", i, nd); end
            checks++; if (bus.lo !== 32'hFFFFFFFF) begin failures++; $display("FAIL dz_lo[%0d]: got %h expected ffffffff", i, bus.lo); end
            checks++; if (bus.hi !== e.hi) begin failures++; $display("FAIL dz_hi[%0d]: got %h expected %h", i, bus.hi, e.hi); end
            checks++; if (bus.div_zero !== 1'b1) begin failures++; $display("FAIL dz_pulse[%0d]: got %b expected 1", i, bus.div_zero); end
            idle_cycle(3'b000, 32'h0);
            checks++; if (bus.div_zero !== 1'b0) begin failures++; $display("FAIL dz_clear[%0d]: got %b expected 0", i, bus.div_zero); end
        end
    endtask

    task automatic test_hazard();
        int nb, ns, nd;
        exp_t e;
        // Held mflo is stalled for the whole sequence, then reads the new LO.
        issue_start(2'b00, 32'h00012345, 32'hFFFFFF00, 1'b1);
        wait_idle(3'b010, 2'b00, 32'h0, 32'h0, 1'b1, nb, ns, nd);
        e = sb.pop_front();
        checks++; if (ns != 33) begin failures++; $display("FAIL hz_mflo_stall: got %0d cycles expected 33", ns); end
        checks++; if (bus.stall !== 1'b0) begin failures++; $display("FAIL hz_mflo_release: got %b expected 0", bus.stall); end
        checks++; if (bus.hilo_rdata !== e.lo) begin failures++; $display("FAIL hz_mflo_data: got %h expected %h", bus.hilo_rdata, e.lo); end
        // Held mthi must not write HI until it is serviced.
        issue_start(2'b01, 32'h00000003, 32'h00000005, 1'b1);
        wait_idle(3'b101, 2'b00, 32'hDEADBEEF, 32'h0, 1'b0, nb, ns, nd);
        e = sb.pop_front();
        checks++; if (ns != 33) begin failures++; $display("FAIL hz_mthi_stall: got %0d expected 33", ns); end
        checks++; if (bus.hi !== e.hi) begin failures++; $display("FAIL hz_mthi_held: got %h expected %h", bus.hi, e.hi); end
        idle_cycle(3'b000, 32'h0);
        checks++; if (bus.hi !== 32'hDEADBEEF) begin failures++; $display("FAIL hz_mthi_late: got %h expected deadbeef", bus.hi); end
        checks++; if (bus.lo !== e.lo) begin failures++; $display("FAIL hz_mthi_lo: got %h expected %h", bus.lo, e.lo); end
        checks++; if (bus.hilo_rdata !== 32'h0) begin failures++; $display("FAIL rdata_none: got %h expected 0", bus.hilo_rdata); end
        // Idle moves: single cycle, no stall.
        idle_cycle(3'b101, 32'hAAAA5555);
        checks++; if (bus.stall !== 1'b0 || bus.busy !== 1'b0) begin failures++; $display("FAIL mthi_idle_stall: got stall=%b busy=%b expected 0/0", bus.stall, bus.busy); end
        idle_cycle(3'b100, 32'h0);
        checks++; if (bus.hilo_rdata !== 32'hAAAA5555) begin failures++; $display("FAIL mfhi_data: got %h expected aaaa5555", bus.hilo_rdata); end
        idle_cycle(3'b011, 32'h13579BDF);
        idle_cycle(3'b010, 32'h0);
        checks++; if (bus.hilo_rdata !== 32'h13579BDF) begin failures++; $display("FAIL mflo_data: got %h expected 13579bdf", bus.hilo_rdata); end
        checks++; if (bus.hi !== 32'hAAAA5555) begin failures++; $display("FAIL mtlo_keeps_hi: got %h expected aaaa5555", bus.hi); end
    endtask

    task automatic test_back_to_back();
        int nb, ns, nd;
        exp_t e;
        issue_start(2'b00, 32'hFFFF0001, 32'h00007FFF, 1'b1);
        // Second start held through the first sequence; accepted in the first idle cycle.
        wait_idle(3'b111, 2'b10, 32'hFFFFFF9C, 32'h00000007, 1'b0, nb, ns, nd);
        e = sb.pop_front();
        sb.push_back(model(2'b10, 32'hFFFFFF9C, 32'h00000007));
        checks++; if (ns != 33) begin failures++; $display("FAIL b2b_stall: got %0d expected 33", ns); end
        checks++; if (bus.hi !== e.hi || bus.lo !== e.lo) begin failures++; $display("FAIL b2b_first: got %h_%h expected %h_%h", bus.hi, bus.lo, e.hi, e.lo); end
        wait_idle(3'b000, 2'b00, 32'h0, 32'h0, 1'b1, nb, ns, nd);
        e = sb.pop_front();
        checks++; if (nb != 33) begin failures++; $display("FAIL b2b_busy2: got %0d expected 33", nb); end
        checks++; if (bus.hi !== e.hi || bus.lo !== e.lo) begin failures++; $display("FAIL b2b_second: got %h_%h expected %h_%h", bus.hi, bus.lo, e.hi, e.lo); end
    endtask

    task automatic test_reset_midop();
        idle_cycle(3'b101, 32'h5A5A5A5A);
        idle_cycle(3'b011, 32'h0F0F0F0F);
        issue_start(2'b00, 32'h00000007, 32'h00000009, 1'b0);
        for (int i = 1; i < 10; i++) idle_cycle(3'b000, 32'h0);
        @(negedge clk);
        reset         = 1'b0;
        bus.hilo_type = 3'b000;
        #1;
        @(negedge clk);
        reset         = 1'b1;
        bus.hilo_type = 3'b100;
        #1;
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL rst_mid_busy: got %b expected 0", bus.busy); end
        checks++; if (bus.stall !== 1'b0) begin failures++; $display("FAIL rst_mid_stall: got %b expected 0", bus.stall); end
        checks++; if (bus.hi !== 32'h0 || bus.lo !== 32'h0) begin failures++; $display("FAIL rst_mid_hilo: got %h_%h expected 0_0", bus.hi, bus.lo); end
        checks++; if (bus.hilo_rdata !== 32'h0) begin failures++; $display("FAIL rst_mid_mfhi: got %h expected 0", bus.hilo_rdata); end
        for (int i = 0; i < 40; i++) idle_cycle(3'b000, 32'h0);
        checks++; if (bus.hi !== 32'h0 || bus.lo !== 32'h0 || bus.busy !== 1'b0) begin failures++; $display("FAIL rst_mid_late: got %h_%h busy=%b expected 0_0 busy=0", bus.hi, bus.lo, bus.busy); end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_div_zero();
        test_hazard();
        test_back_to_back();
        test_reset_midop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hilo_muldiv_sequencer.md
Name: hilo_muldiv_sequencer

Overview:
Iterative multiply/divide unit and sequencer for the HI/LO register pair of the single-cycle MIPS core. It decodes the control unit's HiLotype field and runs mult/multu/div/divu as a 32-step shift-add or restoring-divide sequence. It services mthi/mtlo/mfhi/mflo and drives a stall back to the PC/fetch logic while a sequence is in flight. It sits beside the register file and ALU, fed from rs/rt read data.

Parameters:
WIDTH, 32, operand, HI and LO width.
CNT_W, 5, iteration counter width; covers WIDTH steps.

Ports:
clk  input  1  rising-edge clock.
reset  input  1  reset, synchronous, active-low.
hilo_type  input  3  control-unit HiLotype: 111 start mul/div, 101 mthi, 011 mtlo, 100 mfhi, 010 mflo, 000 none. Other codes are treated as none.
md_sel  input  2  funct[1:0]: bit1 selects div when 1 and mult when 0; bit0 selects unsigned when 1.
rs_data  input  WIDTH  multiplicand or dividend; mthi/mtlo source.
rt_data  input  WIDTH  multiplier or divisor.
hi  output  WIDTH  HI register.
lo  output  WIDTH  LO register.
hilo_rdata  output  WIDTH  mfhi gives hi, mflo gives lo, all other codes give 0. Combinational.
stall  output  1  combinational; high when busy=1 and hilo_type is not 000.
busy  output  1  a sequence is in flight.
div_zero  output  1  one-cycle pulse when a divide with rt=0 completes.

Behaviour:
- Reset (reset=0 at a rising edge):
  - state goes to IDLE; hi, lo, counter and internal accumulators go to 0; busy=0, div_zero=0.
  - A sequence in flight is aborted; its result is discarded.
- States: IDLE, CALC, FIX.
- IDLE:
  - On hilo_type=111 in cycle T, the edge ending T latches |rs| and |rt| (raw values if unsigned), the sign bits and md_sel, clears the counter, and moves to CALC.
  - mthi/mtlo write hi/lo from rs_data at the edge ending the cycle; single cycle; no busy.
- CALC, cycles T+1..T+32: one iteration per cycle; the counter increments and wraps 31 to 0, at which point the state moves to FIX.
  - Multiply: 2*WIDTH-bit shift-add product.
  - Divide: restoring divide, one quotient bit per cycle, MSB first.
- FIX, cycle T+33: sign correction, then hi/lo are written at the edge ending T+33; the state returns to IDLE.
  - Signed mult: product negated if sign(rs) XOR sign(rt).
  - Signed div: quotient negated if sign(rs) XOR sign(rt); remainder takes the sign of rs.
  - Results: mult gives hi=product[63:32], lo=product[31:0]; div gives lo=quotient, hi=remainder.
- busy is high for cycles T+1..T+33. Total latency: results are readable in cycle T+34.
- Stall rules:
  - While busy, any hilo_type other than 000 (mfhi, mflo, mthi, mtlo or a new start) asserts stall. The instruction is held and re-presented.
  - It is serviced in cycle T+34 with the updated hi/lo.
  - While stalled, hi/lo are not written by the held instruction.
- Divide by zero (rt=0, all variants): full 34-cycle latency. Result lo=32'hFFFFFFFF, hi=rs_data as latched at start. div_zero pulses high in cycle T+34 only.
- Signed overflow 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0, no flag.
- Non-HI/LO instructions (hilo_type=000) never stall and never disturb a sequence in flight.
- Operands are captured at start; changes on rs_data/rt_data during CALC have no effect.

Test Plan:
- Signed mult: hilo_type=111, md_sel=00, rs=0xFFFFFFFF, rt=0x00000002 -> busy high for 33 cycles; in cycle T+34 hi=0xFFFFFFFF, lo=0xFFFFFFFE.
- Unsigned mult: md_sel=01, same operands -> hi=0x00000001, lo=0xFFFFFFFE.
- Signed div: md_sel=10, rs=0xFFFFFFF9 (-7), rt=0x00000002 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then rs=0x80000000, rt=0xFFFFFFFF -> lo=0x80000000, hi=0.
- Divu by zero: md_sel=11, rs=0x12345678, rt=0 -> lo=0xFFFFFFFF, hi=0x12345678; div_zero high only in cycle T+34.
- Hazard: issue mflo in cycle T+1 and hold it -> stall=1 through T+33, stall=0 in T+34, hilo_rdata equals new lo. mthi 0xAAAA5555 while idle -> hi=0xAAAA5555 next cycle, no stall.
- Reset mid-op: start mult, drive reset=0 at T+10 -> next cycle busy=0, hi=lo=0, stall=0; a subsequent mfhi returns 0.
